// File: rtl/lock_release_timer.sv
// lock_release_timer
//  Timed release companion for the ship lock latch. While the latched lock level is
//  high, counts HOLD_FRAMES rising edges of the frame strobe, then emits a single-cycle
//  'unlocked' pulse that clears the latch. An early 'cancel' shortens the hold.
//  Optional sprite flicker output is built only when LOCK_BLINK_EN is defined;
//  otherwise blink is tied low and no phase logic exists.
module lock_release_timer #(
   parameter int CNT_W        = 8,
   parameter int HOLD_FRAMES  = 180,
   parameter int BLINK_FRAMES = 4
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             locked_in,
   input  logic             frame_tick,
   input  logic             cancel,
   output logic             unlocked,
   output logic             busy,
   output logic [CNT_W-1:0] frames_left,
   output logic             blink
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

   // Out-of-range hold/blink lengths would make the counter start at 0 or wrap.
   if (HOLD_FRAMES < 1 || HOLD_FRAMES > (1 << CNT_W) - 1 ||
       BLINK_FRAMES < 1 || BLINK_FRAMES > (1 << CNT_W) - 1) begin : g_param_check
      $error("lock_release_timer: HOLD_FRAMES or BLINK_FRAMES outside 1..2^CNT_W-1");
   end

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      COUNT      = 2'd1,
      RELEASE    = 2'd2,
      WAIT_CLEAR = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] frames_nxt;
   logic             unlocked_nxt;
   logic             busy_nxt;
   logic             frame_tick_d;
   logic             fr_edge;

   // A frame is counted on the 0->1 transition of the strobe level only.
   assign fr_edge = frame_tick & ~frame_tick_d;

   // Strobe history; resets high so a strobe already high at reset release is not an edge.
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_tick_d <= 1'b1;
      end else begin
         frame_tick_d <= frame_tick;
      end
   end

   // State and registered outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state       <= IDLE;
         unlocked    <= 1'b0;
         busy        <= 1'b0;
         frames_left <= CNT_ZERO;
      end else begin
         state       <= state_nxt;
         unlocked    <= unlocked_nxt;
         busy        <= busy_nxt;
         frames_left <= frames_nxt;
      end
   end

   // Next-state and next-output decode; COUNT branches are ordered by priority.
   always_comb begin
      state_nxt  = state;
      frames_nxt = frames_left;
      case (state)
         IDLE: begin
            frames_nxt = CNT_ZERO;
            if (locked_in) begin
               state_nxt  = COUNT;
               frames_nxt = HOLD_LOAD;
            end
         end
         COUNT: begin
            if (!locked_in) begin
               // Lock removed externally: abort silently.
               state_nxt  = IDLE;
               frames_nxt = CNT_ZERO;
            end else if (cancel) begin
               // Cancel wins over a coincident frame edge, so no decrement shows.
               state_nxt  = RELEASE;
               frames_nxt = CNT_ZERO;
            end else if (fr_edge) begin
               // Release on the last frame instead of decrementing to 0; never wraps.
               if (frames_left <= CNT_ONE) begin
                  state_nxt  = RELEASE;
                  frames_nxt = CNT_ZERO;
               end else begin
                  frames_nxt = frames_left - CNT_ONE;
               end
            end
         end
         RELEASE: begin
            state_nxt  = WAIT_CLEAR;
            frames_nxt = CNT_ZERO;
         end
         WAIT_CLEAR: begin
            // Hold here until the latch drops so only one pulse per lock episode.
            frames_nxt = CNT_ZERO;
            if (!locked_in) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            frames_nxt = CNT_ZERO;
         end
      endcase
      unlocked_nxt = (state_nxt == RELEASE);
      busy_nxt     = (state_nxt != IDLE);
   end

`ifdef LOCK_BLINK_EN
   localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES);

   logic [CNT_W-1:0] blink_phase;
   logic [CNT_W-1:0] blink_phase_nxt;
   logic             blink_nxt;

   // Flicker phase: forced on at COUNT entry, toggles every BLINK_FRAMES counted edges.
   always_comb begin
      blink_phase_nxt = blink_phase;
      blink_nxt       = 1'b0;
      if (state_nxt == COUNT) begin
         if (state != COUNT) begin
            blink_phase_nxt = BLINK_LOAD;
            blink_nxt       = 1'b1;
         end else begin
            blink_nxt = blink;
            if (fr_edge) begin
               if (blink_phase <= CNT_ONE) begin
                  blink_phase_nxt = BLINK_LOAD;
                  blink_nxt       = ~blink;
               end else begin
                  blink_phase_nxt = blink_phase - CNT_ONE;
               end
            end
         end
      end
   end

   // Flicker registers; blink is low outside COUNT.
   always_ff @(posedge pclk) begin
      if (rst) begin
         blink_phase <= CNT_ZERO;
         blink       <= 1'b0;
      end else begin
         blink_phase <= blink_phase_nxt;
         blink       <= blink_nxt;
      end
   end
`else
   assign blink = 1'b0;
`endif

endmodule
